// File: rtl/rs_param_if.sv
// Dispatch, broadcast and issue bundle of the reservation station.
// The RS is the slave side; dispatch, the result buses and the units are the master side.
interface rs_param_if #(
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
);
   logic              flush;
   logic              disp_valid, disp_ready, disp_is_mem, disp_is_branch;
   logic [OP_W-1:0]   disp_op;
   logic [TAG_W-1:0]  disp_des, disp_q1, disp_q2;
   logic [DATA_W-1:0] disp_v1, disp_v2, disp_imm;
   logic [TAG_W-1:0]  alu_cdb_tag, mem_cdb_tag;
   logic [DATA_W-1:0] alu_cdb_data, mem_cdb_data;
   logic              alu_iss_valid, alu_iss_ready, alu_is_branch;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_v1, alu_v2;
   logic [TAG_W-1:0]  alu_des;
   logic              mem_iss_valid, mem_iss_ready;
   logic [OP_W-1:0]   mem_op;
   logic [DATA_W-1:0] mem_v1, mem_v2, mem_imm;
   logic [TAG_W-1:0]  mem_des;
   logic [4:0]        alu_count, mem_count;

   modport master (
      output flush, disp_valid, disp_is_mem, disp_is_branch, disp_op, disp_des,
             disp_q1, disp_q2, disp_v1, disp_v2, disp_imm,
             alu_cdb_tag, alu_cdb_data, mem_cdb_tag, mem_cdb_data,
             alu_iss_ready, mem_iss_ready,
      input  disp_ready, alu_iss_valid, alu_op, alu_v1, alu_v2, alu_des, alu_is_branch,
             mem_iss_valid, mem_op, mem_v1, mem_v2, mem_imm, mem_des, alu_count, mem_count
   );

   modport slave (
      input  flush, disp_valid, disp_is_mem, disp_is_branch, disp_op, disp_des,
             disp_q1, disp_q2, disp_v1, disp_v2, disp_imm,
             alu_cdb_tag, alu_cdb_data, mem_cdb_tag, mem_cdb_data,
             alu_iss_ready, mem_iss_ready,
      output disp_ready, alu_iss_valid, alu_op, alu_v1, alu_v2, alu_des, alu_is_branch,
             mem_iss_valid, mem_op, mem_v1, mem_v2, mem_imm, mem_des, alu_count, mem_count
   );
endinterface

// File: rtl/rs_param.sv
// Parametrised two-partition reservation station (ALU/branch + memory) with oldest-ready issue.
// Optional RS_STATS_EN adds saturating stall_cnt / issue_cnt counters.
module rs_part #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32,
   parameter int OP_W   = 5,
   parameter int SW     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              alloc_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [TAG_W-1:0]  des_i,
   input  logic [TAG_W-1:0]  q1_i,
   input  logic [TAG_W-1:0]  q2_i,
   input  logic [DATA_W-1:0] v1_i,
   input  logic [DATA_W-1:0] v2_i,
   input  logic [SW-1:0]     side_i,
   input  logic [TAG_W-1:0]  a_tag_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic [TAG_W-1:0]  m_tag_i,
   input  logic [DATA_W-1:0] m_data_i,
   input  logic              iss_ready_i,
   output logic              free_o,
   output logic              iss_valid_o,
   output logic [OP_W-1:0]   op_o,
   output logic [DATA_W-1:0] v1_o,
   output logic [DATA_W-1:0] v2_o,
   output logic [TAG_W-1:0]  des_o,
   output logic [SW-1:0]     side_o,
   output logic [4:0]        count_o
);
   localparam int IW = $clog2(DEPTH);
   localparam int AW = IW + 1;

   // age is a dense rank among resident entries: 0 = oldest
   typedef struct packed {
      logic              vld;
      logic [AW-1:0]     age;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  des, q1, q2;
      logic [DATA_W-1:0] v1, v2;
      logic [SW-1:0]     side;
   } ent_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  des;
      logic [DATA_W-1:0] v1, v2;
      logic [SW-1:0]     side;
   } pay_t;

   ent_t          ent_q [DEPTH];
   ent_t          ent_d [DEPTH];
   pay_t          pay_q, pay_d;
   logic          ivld_q, ivld_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          sel_ok, fre_ok, mv, alloc;
   logic [IW-1:0] sel, fre;
   logic [AW-1:0] sel_age;

   function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0] q,
                                                    input logic [DATA_W-1:0] v);
      if (q != '0 && q == a_tag_i)      return {{TAG_W{1'b0}}, a_data_i};
      else if (q != '0 && q == m_tag_i) return {{TAG_W{1'b0}}, m_data_i};
      else                              return {q, v};
   endfunction

   // a waiting source that misses both buses parks with value 0
   function automatic logic [TAG_W+DATA_W-1:0] cap(input logic [TAG_W-1:0] q,
                                                   input logic [DATA_W-1:0] v);
      if (q == '0) return {q, v};
      else         return wake(q, '0);
   endfunction

   always_comb begin
      ent_d   = ent_q;
      pay_d   = pay_q;
      ivld_d  = ivld_q;
      cnt_d   = cnt_q;
      sel_ok  = 1'b0;
      sel     = '0;
      sel_age = '0;
      fre_ok  = 1'b0;
      fre     = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_q[i].vld && ent_q[i].q1 == '0 && ent_q[i].q2 == '0 &&
             (!sel_ok || ent_q[i].age < sel_age)) begin
            sel_ok  = 1'b1;
            sel     = IW'(i);
            sel_age = ent_q[i].age;
         end
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!ent_q[i].vld) begin
            fre_ok = 1'b1;
            fre    = IW'(i);
         end
      mv    = sel_ok && (!ivld_q || iss_ready_i);
      alloc = alloc_i && fre_ok;
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
         ivld_d   = 1'b0;
         pay_d.op = '1;
         cnt_d    = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            {ent_d[i].q1, ent_d[i].v1} = wake(ent_q[i].q1, ent_q[i].v1);
            {ent_d[i].q2, ent_d[i].v2} = wake(ent_q[i].q2, ent_q[i].v2);
         end
         if (mv) begin
            pay_d = '{op: ent_q[sel].op, des: ent_q[sel].des, v1: ent_q[sel].v1,
                      v2: ent_q[sel].v2, side: ent_q[sel].side};
            ivld_d = 1'b1;
            ent_d[sel].vld = 1'b0;
            for (int i = 0; i < DEPTH; i++)
               if (ent_q[i].vld && ent_q[i].age > ent_q[sel].age)
                  ent_d[i].age = ent_q[i].age - 1'b1;
         end else if (iss_ready_i) begin
            ivld_d = 1'b0;
         end
         if (alloc) begin
            ent_d[fre].vld  = 1'b1;
            ent_d[fre].age  = AW'(cnt_q) - AW'(mv);
            ent_d[fre].op   = op_i;
            ent_d[fre].des  = des_i;
            ent_d[fre].side = side_i;
            {ent_d[fre].q1, ent_d[fre].v1} = cap(q1_i, v1_i);
            {ent_d[fre].q2, ent_d[fre].v2} = cap(q2_i, v2_i);
         end
         cnt_d = cnt_q + 5'(alloc) - 5'(mv);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         pay_q    <= '0;
         pay_q.op <= '1;
         ivld_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ent_q  <= ent_d;
         pay_q  <= pay_d;
         ivld_q <= ivld_d;
         cnt_q  <= cnt_d;
      end
   end

   assign free_o      = (cnt_q != 5'(DEPTH));
   assign iss_valid_o = ivld_q;
   assign op_o        = pay_q.op;
   assign v1_o        = pay_q.v1;
   assign v2_o        = pay_q.v2;
   assign des_o       = pay_q.des;
   assign side_o      = pay_q.side;
   assign count_o     = cnt_q;
endmodule

module rs_param #(
   parameter int ALU_DEPTH = 4,
   parameter int MEM_DEPTH = 4,
   parameter int TAG_W     = 3,
   parameter int DATA_W    = 32,
   parameter int OP_W      = 5
) (
   input  logic        clk,
   input  logic        rst,
   rs_param_if.slave   bus
`ifdef RS_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] issue_cnt
`endif
);
   logic alu_free, mem_free, alu_alloc, mem_alloc;

   assign bus.disp_ready = bus.disp_is_mem ? mem_free : alu_free;
   assign alu_alloc = bus.disp_valid && !bus.disp_is_mem && alu_free && !bus.flush;
   assign mem_alloc = bus.disp_valid &&  bus.disp_is_mem && mem_free && !bus.flush;

   // ALU side slot carries the branch flag, memory side carries the immediate
   rs_part #(.DEPTH(ALU_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .SW(1)) u_alu (
      .clk(clk), .rst(rst), .flush_i(bus.flush), .alloc_i(alu_alloc),
      .op_i(bus.disp_op), .des_i(bus.disp_des), .q1_i(bus.disp_q1), .q2_i(bus.disp_q2),
      .v1_i(bus.disp_v1), .v2_i(bus.disp_v2), .side_i(bus.disp_is_branch),
      .a_tag_i(bus.alu_cdb_tag), .a_data_i(bus.alu_cdb_data),
      .m_tag_i(bus.mem_cdb_tag), .m_data_i(bus.mem_cdb_data),
      .iss_ready_i(bus.alu_iss_ready), .free_o(alu_free), .iss_valid_o(bus.alu_iss_valid),
      .op_o(bus.alu_op), .v1_o(bus.alu_v1), .v2_o(bus.alu_v2), .des_o(bus.alu_des),
      .side_o(bus.alu_is_branch), .count_o(bus.alu_count)
   );

   rs_part #(.DEPTH(MEM_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .SW(DATA_W)) u_mem (
      .clk(clk), .rst(rst), .flush_i(bus.flush), .alloc_i(mem_alloc),
      .op_i(bus.disp_op), .des_i(bus.disp_des), .q1_i(bus.disp_q1), .q2_i(bus.disp_q2),
      .v1_i(bus.disp_v1), .v2_i(bus.disp_v2), .side_i(bus.disp_imm),
      .a_tag_i(bus.alu_cdb_tag), .a_data_i(bus.alu_cdb_data),
      .m_tag_i(bus.mem_cdb_tag), .m_data_i(bus.mem_cdb_data),
      .iss_ready_i(bus.mem_iss_ready), .free_o(mem_free), .iss_valid_o(bus.mem_iss_valid),
      .op_o(bus.mem_op), .v1_o(bus.mem_v1), .v2_o(bus.mem_v2), .des_o(bus.mem_des),
      .side_o(bus.mem_imm), .count_o(bus.mem_count)
   );

`ifdef RS_STATS_EN
   logic [31:0] stall_q, issue_q;
   logic [1:0]  inc;
   logic [32:0] isum;

   assign inc  = 2'(bus.alu_iss_valid && bus.alu_iss_ready) +
                 2'(bus.mem_iss_valid && bus.mem_iss_ready);
   assign isum = {1'b0, issue_q} + 33'(inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         issue_q <= '0;
      end else begin
         if (bus.disp_valid && !bus.disp_ready && !bus.flush && stall_q != '1)
            stall_q <= stall_q + 32'd1;
         issue_q <= isum[32] ? '1 : isum[31:0];
      end
   end

   assign stall_cnt = stall_q;
   assign issue_cnt = issue_q;
`endif
endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param: issue payloads are scoreboarded, state is checked in-line.
module tb_rs_param;
   localparam int TAG_W = 3, DATA_W = 32, OP_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rs_param_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus();
`ifdef RS_STATS_EN
   logic [31:0] stall_cnt, issue_cnt;
`endif

   rs_param #(.ALU_DEPTH(4), .MEM_DEPTH(4), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef RS_STATS_EN
      , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
   );

   typedef struct packed {
      logic [4:0] op; logic [31:0] v1, v2; logic [2:0] des; logic br;
   } aexp_t;
   typedef struct packed {
      logic [4:0] op; logic [31:0] v1, v2, imm; logic [2:0] des;
   } mexp_t;

   aexp_t aq[$];
   mexp_t mq[$];
   aexp_t ag, ae;
   mexp_t mg, me;
   int nvec = 0, nerr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dsp(input logic m, input logic [4:0] op, input logic [2:0] des,
                      input logic [2:0] q1, input logic [2:0] q2,
                      input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm, input logic br);
      bus.disp_valid = 1'b1; bus.disp_is_mem = m; bus.disp_op = op; bus.disp_des = des;
      bus.disp_q1 = q1; bus.disp_q2 = q2; bus.disp_v1 = v1; bus.disp_v2 = v2;
      bus.disp_imm = imm; bus.disp_is_branch = br;
      tick();
      bus.disp_valid = 1'b0;
   endtask

   // scoreboard side: a handshake seen at negedge completes on the next posedge
   always @(negedge clk) begin
      if (!rst && bus.alu_iss_valid && bus.alu_iss_ready) begin
         ag = '{bus.alu_op, bus.alu_v1, bus.alu_v2, bus.alu_des, bus.alu_is_branch};
         nvec++;
         if (aq.size() == 0) begin
            nerr++;
            $error("FAIL alu_unexpected: observed=%0h expected=none", ag);
         end else begin
            ae = aq.pop_front();
            assert (ag === ae) else begin
               nerr++;
               $error("FAIL alu_issue: observed=%0h expected=%0h", ag, ae);
            end
         end
      end
      if (!rst && bus.mem_iss_valid && bus.mem_iss_ready) begin
         mg = '{bus.mem_op, bus.mem_v1, bus.mem_v2, bus.mem_imm, bus.mem_des};
         nvec++;
         if (mq.size() == 0) begin
            nerr++;
            $error("FAIL mem_unexpected: observed=%0h expected=none", mg);
         end else begin
            me = mq.pop_front();
            assert (mg === me) else begin
               nerr++;
               $error("FAIL mem_issue: observed=%0h expected=%0h", mg, me);
            end
         end
      end
   end

   initial begin
      bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.disp_is_mem = 1'b0; bus.disp_is_branch = 1'b0;
      bus.disp_op = '0; bus.disp_des = '0; bus.disp_q1 = '0; bus.disp_q2 = '0;
      bus.disp_v1 = '0; bus.disp_v2 = '0; bus.disp_imm = '0;
      bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0; bus.mem_cdb_tag = '0; bus.mem_cdb_data = '0;
      bus.alu_iss_ready = 1'b1; bus.mem_iss_ready = 1'b1;

      // reset state
      repeat (2) tick();
      chk("rst_alu_valid", bus.alu_iss_valid, 0);
      chk("rst_mem_valid", bus.mem_iss_valid, 0);
      chk("rst_alu_op", bus.alu_op, 5'h1F);
      chk("rst_mem_op", bus.mem_op, 5'h1F);
      chk("rst_alu_v1", bus.alu_v1, 0);
      chk("rst_alu_cnt", bus.alu_count, 0);
      chk("rst_mem_cnt", bus.mem_count, 0);
      chk("rst_disp_ready", bus.disp_ready, 1);
      rst = 1'b0;
      tick();

      // ready ADD: entry after one edge, payload after two
      aq.push_back('{5'd1, 32'd5, 32'd7, 3'd3, 1'b0});
      dsp(1'b0, 5'd1, 3'd3, 3'd0, 3'd0, 32'd5, 32'd7, 32'd0, 1'b0);
      chk("t1_cnt_e1", bus.alu_count, 1);
      chk("t1_valid_e1", bus.alu_iss_valid, 0);
      tick();
      chk("t1_valid_e2", bus.alu_iss_valid, 1);
      chk("t1_v1", bus.alu_v1, 5);
      chk("t1_v2", bus.alu_v2, 7);
      chk("t1_des", bus.alu_des, 3);
      chk("t1_cnt_e2", bus.alu_count, 0);
      tick();
      chk("t1_drained", bus.alu_iss_valid, 0);

      // LW waiting on tag 2, woken by the memory bus
      mq.push_back('{5'd2, 32'h100, 32'h22, 32'h40, 3'd4});
      dsp(1'b1, 5'd2, 3'd4, 3'd2, 3'd0, 32'd0, 32'h22, 32'h40, 1'b0);
      tick(); tick();
      chk("t2_blocked", bus.mem_iss_valid, 0);
      bus.mem_cdb_tag = 3'd2; bus.mem_cdb_data = 32'h100;
      tick();
      bus.mem_cdb_tag = '0; bus.mem_cdb_data = '0;
      chk("t2_capture_edge", bus.mem_iss_valid, 0);
      chk("t2_mem_cnt", bus.mem_count, 1);
      tick();
      chk("t2_valid", bus.mem_iss_valid, 1);
      chk("t2_v1", bus.mem_v1, 32'h100);
      chk("t2_imm", bus.mem_imm, 32'h40);
      tick();

      // fill ALU: A,C wait on 6, B,D on 5; A,C leave, E,F refill freed slots 0,2
      dsp(1'b0, 5'd3, 3'd1, 3'd6, 3'd0, 32'd0, 32'h101, 32'd0, 1'b0);
      dsp(1'b0, 5'd4, 3'd2, 3'd5, 3'd0, 32'd0, 32'h102, 32'd0, 1'b1);
      dsp(1'b0, 5'd5, 3'd3, 3'd6, 3'd0, 32'd0, 32'h103, 32'd0, 1'b0);
      dsp(1'b0, 5'd6, 3'd4, 3'd5, 3'd0, 32'd0, 32'h104, 32'd0, 1'b0);
      chk("t3_full_cnt", bus.alu_count, 4);
      bus.disp_is_mem = 1'b0; #1;
      chk("t3_alu_ready", bus.disp_ready, 0);
      bus.disp_is_mem = 1'b1; #1;
      chk("t3_mem_ready", bus.disp_ready, 1);
      mq.push_back('{5'd8, 32'h11, 32'h12, 32'h13, 3'd7});
      dsp(1'b1, 5'd8, 3'd7, 3'd0, 3'd0, 32'h11, 32'h12, 32'h13, 1'b0);
      chk("t3_mem_cnt", bus.mem_count, 1);
      dsp(1'b0, 5'd9, 3'd5, 3'd0, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0);
      chk("t3_full_reject", bus.alu_count, 4);
      aq.push_back('{5'd3, 32'h66, 32'h101, 3'd1, 1'b0});
      aq.push_back('{5'd5, 32'h66, 32'h103, 3'd3, 1'b0});
      bus.alu_cdb_tag = 3'd6; bus.alu_cdb_data = 32'h66;
      tick();
      bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0;
      repeat (3) tick();
      chk("t3_after6_cnt", bus.alu_count, 2);
      dsp(1'b0, 5'd10, 3'd5, 3'd5, 3'd0, 32'd0, 32'h105, 32'd0, 1'b0);
      dsp(1'b0, 5'd11, 3'd6, 3'd5, 3'd0, 32'd0, 32'h106, 32'd0, 1'b0);
      chk("t3_refill_cnt", bus.alu_count, 4);
      aq.push_back('{5'd4, 32'h55, 32'h102, 3'd2, 1'b1});
      aq.push_back('{5'd6, 32'h55, 32'h104, 3'd4, 1'b0});
      aq.push_back('{5'd10, 32'h55, 32'h105, 3'd5, 1'b0});
      aq.push_back('{5'd11, 32'h55, 32'h106, 3'd6, 1'b0});
      bus.alu_cdb_tag = 3'd5; bus.alu_cdb_data = 32'h55;
      tick();
      bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0;
      repeat (6) tick();
      chk("t3_drain_cnt", bus.alu_count, 0);
      chk("t3_alu_q_empty", aq.size(), 0);

      // capture at dispatch and bus priority
      aq.push_back('{5'd12, 32'd1, 32'hDEAD, 3'd1, 1'b0});
      bus.alu_cdb_tag = 3'd4; bus.alu_cdb_data = 32'hDEAD;
      bus.mem_cdb_tag = 3'd4; bus.mem_cdb_data = 32'hBEEF;
      dsp(1'b0, 5'd12, 3'd1, 3'd0, 3'd4, 32'd1, 32'd0, 32'd0, 1'b0);
      bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0;
      aq.push_back('{5'd13, 32'hBEEF, 32'd2, 3'd2, 1'b0});
      dsp(1'b0, 5'd13, 3'd2, 3'd4, 3'd0, 32'd0, 32'd2, 32'd0, 1'b0);
      bus.mem_cdb_tag = '0; bus.mem_cdb_data = '0;
      dsp(1'b0, 5'd14, 3'd3, 3'd3, 3'd0, 32'd0, 32'd3, 32'd0, 1'b0);
      tick();
      aq.push_back('{5'd14, 32'hA1, 32'd3, 3'd3, 1'b0});
      bus.alu_cdb_tag = 3'd3; bus.alu_cdb_data = 32'hA1;
      bus.mem_cdb_tag = 3'd3; bus.mem_cdb_data = 32'hB1;
      tick();
      bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0;
      bus.mem_cdb_tag = '0; bus.mem_cdb_data = '0;
      repeat (5) tick();
      chk("t4_alu_q_empty", aq.size(), 0);

      // backpressure: payload held, then back-to-back drain
      bus.alu_iss_ready = 1'b0;
      aq.push_back('{5'd15, 32'd1, 32'd1, 3'd1, 1'b0});
      aq.push_back('{5'd16, 32'd2, 32'd2, 3'd2, 1'b0});
      aq.push_back('{5'd17, 32'd3, 32'd3, 3'd3, 1'b0});
      dsp(1'b0, 5'd15, 3'd1, 3'd0, 3'd0, 32'd1, 32'd1, 32'd0, 1'b0);
      dsp(1'b0, 5'd16, 3'd2, 3'd0, 3'd0, 32'd2, 32'd2, 32'd0, 1'b0);
      dsp(1'b0, 5'd17, 3'd3, 3'd0, 3'd0, 32'd3, 32'd3, 32'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("t5_hold_valid", bus.alu_iss_valid, 1);
         chk("t5_hold_des", bus.alu_des, 1);
         chk("t5_hold_cnt", bus.alu_count, 2);
         tick();
      end
      bus.alu_iss_ready = 1'b1;
      tick();
      chk("t5_b2b_valid1", bus.alu_iss_valid, 1);
      chk("t5_b2b_des1", bus.alu_des, 2);
      tick();
      chk("t5_b2b_valid2", bus.alu_iss_valid, 1);
      chk("t5_b2b_des2", bus.alu_des, 3);
      tick();
      chk("t5_b2b_done", bus.alu_iss_valid, 0);

      // flush with a held payload, 3 ALU entries and a waiting memory entry
      bus.alu_iss_ready = 1'b0;
      dsp(1'b1, 5'd22, 3'd5, 3'd7, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      dsp(1'b0, 5'd18, 3'd1, 3'd0, 3'd0, 32'd1, 32'd1, 32'd0, 1'b0);
      dsp(1'b0, 5'd19, 3'd2, 3'd0, 3'd0, 32'd2, 32'd2, 32'd0, 1'b0);
      dsp(1'b0, 5'd20, 3'd3, 3'd0, 3'd0, 32'd3, 32'd3, 32'd0, 1'b0);
      dsp(1'b0, 5'd21, 3'd4, 3'd0, 3'd0, 32'd4, 32'd4, 32'd0, 1'b0);
      chk("t6_pre_cnt", bus.alu_count, 3);
      chk("t6_pre_valid", bus.alu_iss_valid, 1);
      bus.flush = 1'b1;
      dsp(1'b0, 5'd23, 3'd6, 3'd0, 3'd0, 32'd6, 32'd6, 32'd0, 1'b0);
      bus.flush = 1'b0;
      chk("t6_alu_cnt", bus.alu_count, 0);
      chk("t6_mem_cnt", bus.mem_count, 0);
      chk("t6_alu_valid", bus.alu_iss_valid, 0);
      chk("t6_alu_op", bus.alu_op, 5'h1F);
      chk("t6_mem_op", bus.mem_op, 5'h1F);
      bus.alu_iss_ready = 1'b1;
      repeat (3) tick();
      chk("t6_no_store", bus.alu_count, 0);
      chk("t6_no_issue", bus.alu_iss_valid, 0);

      // asynchronous reset between clock edges
      dsp(1'b0, 5'd24, 3'd7, 3'd5, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk("t7_pre_cnt", bus.alu_count, 1);
      #2 rst = 1'b1;
      #1;
      chk("t7_async_cnt", bus.alu_count, 0);
      chk("t7_async_op", bus.alu_op, 5'h1F);
      #3 rst = 1'b0;
      tick();
      chk("t7_post_cnt", bus.alu_count, 0);

      chk("end_alu_q_empty", aq.size(), 0);
      chk("end_mem_q_empty", mq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
